// File: rtl/nibble_serial_accumulator_pkg.sv
// Shared definitions for the nibble-serial accumulator.
//   state_e      : controller state (IDLE / RUN)
//   NIBBLE_W     : width of the single adder slice
//   cnt_width()  : nibble counter width, never below 1 bit
package nibble_serial_accumulator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int NIBBLE_W = 4;

  function automatic int cnt_width(input int nibbles);
    int w;
    w = $clog2(nibbles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// 4-bit adder slice with carry in/out; one 74AC283 package.
//   A, B : addends
//   CI   : carry in
//   S    : sum
//   CO   : carry out
// Kept as one 5-bit add so the mapper sees a single adder cell.
module nibble_add4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CI,
  output logic [3:0] S,
  output logic       CO
);

  assign {CO, S} = {1'b0, A} + {1'b0, B} + {4'b0000, CI};

endmodule

// File: rtl/nibble_serial_accumulator.sv
// Multi-cycle accumulator: adds a WIDTH-bit operand into ACC one nibble per
// clock through a single 4-bit adder slice plus a carry flop.
//   CLK, RST_N          : clock, synchronous active-low reset
//   IN_VALID/IN_READY   : operand handshake
//   IN_DATA, IN_CLEAR   : operand; clear = load instead of add
//   ACC, ACC_VALID      : accumulator, one-cycle completion strobe
//   OVF                 : carry out of the last completed operation
//   BUSY                : operation in progress
module nibble_serial_accumulator
  import nibble_serial_accumulator_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_CLEAR,
  output logic [WIDTH-1:0] ACC,
  output logic             ACC_VALID,
  output logic             OVF,
  output logic             BUSY
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_accumulator: WIDTH must be a multiple of 4 and >= 8");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic             clr_q, clr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             acc_valid_q, acc_valid_d;

  logic [NIBBLE_W-1:0] add_a, add_b, add_s;
  logic                add_co;

  assign IN_READY  = RST_N && (state_q == IDLE);
  assign BUSY      = (state_q == RUN);
  assign ACC       = acc_q;
  assign ACC_VALID = acc_valid_q;
  assign OVF       = ovf_q;

  // Select the nibble pair addressed by the counter; a clear operation
  // feeds zero in place of the old accumulator nibble.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (cnt_q == CNT_W'(n)) begin
        add_a = acc_q[n*NIBBLE_W +: NIBBLE_W];
        add_b = opd_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
    if (clr_q) add_a = '0;
  end

  nibble_add4 u_add (
    .A  (add_a),
    .B  (add_b),
    .CI (carry_q),
    .S  (add_s),
    .CO (add_co)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opd_d       = opd_q;
    clr_d       = clr_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    acc_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (IN_VALID && IN_READY) begin
          opd_d   = IN_DATA;
          clr_d   = IN_CLEAR;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Write the sum back in place; other nibbles hold.
        for (int n = 0; n < NIBBLES; n++) begin
          if (cnt_q == CNT_W'(n)) acc_d[n*NIBBLE_W +: NIBBLE_W] = add_s;
        end
        carry_d = add_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = IDLE;
          ovf_d       = add_co;
          acc_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      opd_q       <= '0;
      clr_q       <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      opd_q       <= opd_d;
      clr_q       <= clr_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      acc_valid_q <= acc_valid_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_accumulator.sv
// Bench for nibble_serial_accumulator: a 16-bit and an 8-bit instance.
// Expected {ACC, OVF} are pushed to a queue at accept and popped when the
// DUT strobes ACC_VALID.
module tb_nibble_serial_accumulator;

  typedef struct {
    logic [15:0] acc;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid = 1'b0, in_clear = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, acc_valid, ovf, busy;
  logic [15:0] acc;

  // 8-bit instance
  logic        in_valid8 = 1'b0, in_clear8 = 1'b0;
  logic [7:0]  in_data8 = '0;
  logic        in_ready8, acc_valid8, ovf8, busy8;
  logic [7:0]  acc8;

  nibble_serial_accumulator #(.WIDTH(16)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_DATA(in_data), .IN_CLEAR(in_clear), .ACC(acc), .ACC_VALID(acc_valid),
    .OVF(ovf), .BUSY(busy)
  );

  nibble_serial_accumulator #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid8), .IN_READY(in_ready8),
    .IN_DATA(in_data8), .IN_CLEAR(in_clear8), .ACC(acc8), .ACC_VALID(acc_valid8),
    .OVF(ovf8), .BUSY(busy8)
  );

  int n_checks = 0;
  int n_errors = 0;

  exp_t q16[$];
  exp_t q8[$];
  logic [15:0] m_acc16 = '0;
  logic [7:0]  m_acc8  = '0;

  // Reference model: compute the expected result of an accepted operand.
  function automatic exp_t model16(input logic [15:0] d, input logic clr);
    logic [16:0] s;
    exp_t e;
    s = {1'b0, (clr ? 16'h0 : m_acc16)} + {1'b0, d};
    e.acc = s[15:0];
    e.ovf = s[16];
    return e;
  endfunction

  // Scoreboard consumers
  always @(negedge clk) begin
    if (acc_valid) begin
      exp_t e;
      n_checks++;
      if (q16.size() == 0) begin
        n_errors++;
        $display("FAIL sb16_spurious: ACC_VALID high, acc=%h, none expected", acc);
      end else begin
        e = q16.pop_front();
        n_checks++;
        if (acc !== e.acc || ovf !== e.ovf) begin
          n_errors++;
          $display("FAIL sb16_result: got acc=%h ovf=%b, expected acc=%h ovf=%b",
                   acc, ovf, e.acc, e.ovf);
        end
      end
    end
    if (acc_valid8) begin
      exp_t e;
      n_checks++;
      if (q8.size() == 0) begin
        n_errors++;
        $display("FAIL sb8_spurious: ACC_VALID high, acc=%h, none expected", acc8);
      end else begin
        e = q8.pop_front();
        n_checks++;
        if (acc8 !== e.acc[7:0] || ovf8 !== e.ovf) begin
          n_errors++;
          $display("FAIL sb8_result: got acc=%h ovf=%b, expected acc=%h ovf=%b",
                   acc8, ovf8, e.acc[7:0], e.ovf);
        end
      end
    end
  end

  // Issue one 16-bit operation and wait for its strobe; checks latency,
  // IN_READY low / BUSY high while running, and a single-cycle strobe.
  task automatic op16(input logic [15:0] d, input logic clr, input string name);
    int n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_clear = clr;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (!in_ready) begin
      n_errors++;
      $display("FAIL %s_ready_timeout: in_ready=%b, expected 1", name, in_ready);
    end
    e = model16(d, clr);
    m_acc16 = e.acc;
    q16.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; in_data = 16'hDEAD;
    n = 1;
    while (!acc_valid && n < 50) begin
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL %s_run_flags: in_ready=%b busy=%b at cycle %0d, expected 0/1",
                 name, in_ready, busy, n);
      end
      @(negedge clk); n++;
    end
    n_checks++;
    if (n != 5) begin
      n_errors++;
      $display("FAIL %s_latency: result in cycle %0d, expected 5", name, n);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_ready_at_valid: in_ready=%b, expected 1", name, in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (acc_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_strobe_width: acc_valid=%b one cycle later, expected 0", name, acc_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (acc !== 16'h0 || ovf !== 1'b0 || acc_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: acc=%h ovf=%b av=%b busy=%b rdy=%b, expected 0000/0/0/0/0",
               acc, ovf, acc_valid, busy, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready: in_ready=%b in_ready8=%b, expected 1/1", in_ready, in_ready8);
    end
  endtask

  task automatic test_load();
    op16(16'h1234, 1'b1, "load");
  endtask

  task automatic test_carry_ripple();
    op16(16'h0FFF, 1'b1, "ripple_load");
    op16(16'h0001, 1'b0, "ripple_add");
  endtask

  task automatic test_overflow();
    op16(16'hFFFF, 1'b1, "ovf_load");
    op16(16'h0001, 1'b0, "ovf_wrap");
    op16(16'h0002, 1'b0, "ovf_clear");
  endtask

  task automatic test_back_to_back();
    int n, first_acc, second_acc;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0100; in_clear = 1'b0;
    // Walk cycles with IN_VALID high; push at each accept.
    first_acc = -1; second_acc = -1;
    for (n = 0; n < 30 && second_acc < 0; n++) begin
      if (in_ready && in_valid) begin
        e = model16(in_data, in_clear);
        m_acc16 = e.acc;
        q16.push_back(e);
        if (first_acc < 0) first_acc = n; else second_acc = n;
      end
      if (first_acc >= 0 && n == first_acc + 2) in_data = 16'h5555;
      if (first_acc >= 0 && n == first_acc + 4) in_data = 16'h0010;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (second_acc - first_acc != 5) begin
      n_errors++;
      $display("FAIL b2b_spacing: accept spacing %0d, expected 5", second_acc - first_acc);
    end
    n = 0;
    while (!acc_valid && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (acc !== 16'h0112) begin
      n_errors++;
      $display("FAIL b2b_final: acc=%h, expected 0112", acc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    op16(16'hFFFF, 1'b0, "pre_abort");   // leaves OVF=1
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h4321; in_clear = 1'b0;
    e = model16(in_data, in_clear);
    q16.push_back(e);
    @(negedge clk);                      // accept edge passed
    in_valid = 1'b0;
    repeat (2) @(negedge clk);           // two RUN edges passed
    rst_n = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_ready_in_reset: in_ready=%b, expected 0", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    void'(q16.pop_back());
    m_acc16 = '0;
    #1;
    n_checks++;
    if (acc !== 16'h0 || ovf !== 1'b0 || acc_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_state: acc=%h ovf=%b av=%b rdy=%b busy=%b, expected 0000/0/0/1/0",
               acc, ovf, acc_valid, in_ready, busy);
    end
    repeat (8) @(negedge clk);           // scoreboard flags any stray strobe
  endtask

  task automatic test_width8();
    int n;
    exp_t e;
    logic [8:0] s;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid8 = 1'b1;
      in_data8  = (k == 0) ? 8'hF0 : 8'h20;
      in_clear8 = (k == 0);
      s = {1'b0, (in_clear8 ? 8'h00 : m_acc8)} + {1'b0, in_data8};
      m_acc8 = s[7:0];
      e.acc = {8'h00, s[7:0]};
      e.ovf = s[8];
      q8.push_back(e);
      @(negedge clk);
      in_valid8 = 1'b0;
      n = 1;
      while (!acc_valid8 && n < 50) begin @(negedge clk); n++; end
      n_checks++;
      if (n != 3) begin
        n_errors++;
        $display("FAIL w8_latency_%0d: result in cycle %0d, expected 3", k, n);
      end
    end
    n_checks++;
    if (acc8 !== 8'h10 || ovf8 !== 1'b1) begin
      n_errors++;
      $display("FAIL w8_final: acc=%h ovf=%b, expected 10/1", acc8, ovf8);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load();
    test_carry_ripple();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    test_width8();
    repeat (3) @(negedge clk);
    n_checks++;
    if (q16.size() != 0 || q8.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d/%0d results outstanding, expected 0/0", q16.size(), q8.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
